// File: rtl/gba_fb_pkg.sv
// Shared frame-buffer geometry, pixel type and fill-engine state encoding
// for the GBA frame-buffer write path.
package gba_fb_pkg;

  localparam logic [7:0]  FB_W     = 8'd240;
  localparam logic [7:0]  FB_H     = 8'd160;
  localparam logic [15:0] FB_DEPTH = 16'd38400;
  localparam int          FB_AW    = 16;

  typedef logic [17:0] rgb6_t;

  typedef enum logic [1:0] {
    FILL_IDLE,
    FILL_RUN,
    FILL_DONE
  } fill_state_e;

endpackage

// File: rtl/gba_fb_addr.sv
// Combinational coordinate range check and linear address y*240 + x
// for the 240x160 frame buffer.
module gba_fb_addr
  import gba_fb_pkg::*;
(
  input  logic [7:0]       x_i,
  input  logic [7:0]       y_i,
  output logic             in_range_o,
  output logic [FB_AW-1:0] addr_o
);

  assign in_range_o = (x_i < FB_W) && (y_i < FB_H);

  // y*240 as (y*256 - y*16); exact for every legal row, no multiplier needed
  assign addr_o = {y_i, 8'h00} - {4'h0, y_i, 4'h0} + {8'h00, x_i};

endmodule

// File: rtl/gba_fb_write_arbiter.sv
// Fixed-priority owner of frame-buffer write port A: GBA pixels, then host,
// then background fill. Define FBW_CLEAR_ON_RESET_EN to start a fill out of reset.
module gba_fb_write_arbiter
  import gba_fb_pkg::*;
#(
  parameter rgb6_t FILL_RESET_COLOR = 18'h20820,
  parameter int    DROP_CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [7:0]            pix_x,
  input  logic [7:0]            pix_y,
  input  rgb6_t                 pix_data,
  input  logic                  pix_we,
  input  logic [7:0]            host_x,
  input  logic [7:0]            host_y,
  input  rgb6_t                 host_data,
  input  logic                  host_valid,
  output logic                  host_ready,
  input  logic                  fill_start,
  input  rgb6_t                 fill_color,
  output logic                  fill_busy,
  output logic                  fill_done,
  output logic                  mem_we,
  output logic [FB_AW-1:0]      mem_addr,
  output rgb6_t                 mem_wdata,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

`ifdef FBW_CLEAR_ON_RESET_EN
  localparam fill_state_e RESET_STATE = FILL_RUN;
`else
  localparam fill_state_e RESET_STATE = FILL_IDLE;
`endif

  fill_state_e           state_q, state_d;
  logic [FB_AW-1:0]      fill_ptr_q, fill_ptr_d;
  rgb6_t                 fill_col_q, fill_col_d;
  logic                  mem_we_q, mem_we_d;
  logic [FB_AW-1:0]      mem_addr_q, mem_addr_d;
  rgb6_t                 mem_wdata_q, mem_wdata_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic             pix_ok, host_ok, fill_gnt, drop_inc;
  logic [FB_AW-1:0] pix_addr, host_addr;

  gba_fb_addr u_pix_addr (
    .x_i        (pix_x),
    .y_i        (pix_y),
    .in_range_o (pix_ok),
    .addr_o     (pix_addr)
  );

  gba_fb_addr u_host_addr (
    .x_i        (host_x),
    .y_i        (host_y),
    .in_range_o (host_ok),
    .addr_o     (host_addr)
  );

  assign host_ready = ~pix_we;
  assign fill_gnt   = (state_q == FILL_RUN) && !pix_we && !host_valid;

  // An out-of-range request still owns its cycle; it just never reaches the BRAM
  always_comb begin
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    drop_inc    = 1'b0;
    if (pix_we) begin
      if (pix_ok) begin
        mem_we_d    = 1'b1;
        mem_addr_d  = pix_addr;
        mem_wdata_d = pix_data;
      end else begin
        drop_inc = 1'b1;
      end
    end else if (host_valid) begin
      if (host_ok) begin
        mem_we_d    = 1'b1;
        mem_addr_d  = host_addr;
        mem_wdata_d = host_data;
      end else begin
        drop_inc = 1'b1;
      end
    end else if (fill_gnt) begin
      mem_we_d    = 1'b1;
      mem_addr_d  = fill_ptr_q;
      mem_wdata_d = fill_col_q;
    end
  end

  assign drop_cnt_d = (drop_inc && (drop_cnt_q != '1)) ? drop_cnt_q + 1'b1 : drop_cnt_q;

  always_comb begin
    state_d    = state_q;
    fill_ptr_d = fill_ptr_q;
    fill_col_d = fill_col_q;
    unique case (state_q)
      FILL_IDLE: begin
        if (fill_start) begin
          state_d    = FILL_RUN;
          fill_ptr_d = '0;
          fill_col_d = fill_color;
        end
      end
      FILL_RUN: begin
        if (fill_gnt) begin
          if (fill_ptr_q == FB_DEPTH - 16'd1) begin
            state_d = FILL_DONE;
          end else begin
            fill_ptr_d = fill_ptr_q + 16'd1;
          end
        end
      end
      FILL_DONE: state_d = FILL_IDLE;
      default:   state_d = FILL_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= RESET_STATE;
      fill_ptr_q  <= '0;
      fill_col_q  <= FILL_RESET_COLOR;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      fill_ptr_q  <= fill_ptr_d;
      fill_col_q  <= fill_col_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign fill_busy = (state_q == FILL_RUN);
  assign fill_done = (state_q == FILL_DONE);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_gba_fb_write_arbiter.sv
// Scoreboard bench for gba_fb_write_arbiter: a per-cycle reference model queues
// expected BRAM writes; a negedge monitor pops and compares them.
module tb_gba_fb_write_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic [7:0]  pix_x, pix_y, host_x, host_y;
  logic [17:0] pix_data, host_data, fill_color, mem_wdata;
  logic        pix_we, host_valid, host_ready, fill_start, fill_busy, fill_done, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  drop_cnt;

  gba_fb_write_arbiter dut (
    .clk        (clk),
    .resetn     (resetn),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_data   (pix_data),
    .pix_we     (pix_we),
    .host_x     (host_x),
    .host_y     (host_y),
    .host_data  (host_data),
    .host_valid (host_valid),
    .host_ready (host_ready),
    .fill_start (fill_start),
    .fill_color (fill_color),
    .fill_busy  (fill_busy),
    .fill_done  (fill_done),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] a;
    logic [17:0] d;
    logic        dn;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  done_seen = 0;

  // Reference model state: fill progress expressed as words issued so far
  bit          m_busy, m_hold;
  int          m_ptr, m_drop, m_done_exp = 0;
  logic [17:0] m_col;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_drop = 0;
    m_hold = 0;
    m_ptr  = 0;
`ifdef FBW_CLEAR_ON_RESET_EN
    m_busy = 1;
    m_col  = 18'h20820;
`else
    m_busy = 0;
    m_col  = 18'h0;
`endif
    exp_q.delete();
  endtask

  task automatic expect_req(input logic [7:0] x, input logic [7:0] y, input logic [17:0] d);
    if (x < 8'd240 && y < 8'd160)
      exp_q.push_back('{a: 16'(int'(y) * 240 + int'(x)), d: d, dn: 1'b0});
    else if (m_drop < 255)
      m_drop++;
  endtask

  // One clock of stimulus; updates the model with what this cycle must write
  task automatic cycle(input logic pw, input logic [7:0] px, input logic [7:0] py,
                       input logic [17:0] pd, input logic hv, input logic [7:0] hx,
                       input logic [7:0] hy, input logic [17:0] hd, input logic fs,
                       input logic [17:0] fc, output logic acc);
    bit b0, h0;
    @(posedge clk);
    #1;
    pix_we = pw; pix_x = px; pix_y = py; pix_data = pd;
    host_valid = hv; host_x = hx; host_y = hy; host_data = hd;
    fill_start = fs; fill_color = fc;
    #1;
    chk("host_ready", host_ready, !pw);
    chk("fill_busy", fill_busy, m_busy);
    chk("drop_cnt", drop_cnt, m_drop);
    b0 = m_busy;
    h0 = m_hold;
    m_hold = 0;
    acc = hv && !pw;
    if (pw) begin
      expect_req(px, py, pd);
    end else if (hv) begin
      expect_req(hx, hy, hd);
    end else if (m_busy) begin
      exp_q.push_back('{a: 16'(m_ptr), d: m_col, dn: (m_ptr == 38399)});
      m_ptr++;
      if (m_ptr == 38400) begin
        m_busy = 0;
        m_hold = 1;
        m_done_exp++;
      end
    end
    if (fs && !b0 && !h0) begin
      m_busy = 1;
      m_ptr  = 0;
      m_col  = fc;
    end
  endtask

  task automatic idle();
    logic a;
    cycle(1'b0, 8'd0, 8'd0, 18'd0, 1'b0, 8'd0, 8'd0, 18'd0, 1'b0, 18'd0, a);
  endtask

  always @(negedge clk) begin
    if (mem_we) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr %0d data %0h expected no write", mem_addr, mem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("mem_write{addr,data,done}", {mem_addr, mem_wdata, fill_done}, {e.a, e.d, e.dn});
      end
    end else begin
      chk("fill_done_without_write", fill_done, 1'b0);
    end
    if (fill_done) begin
      done_seen++;
      chk("busy_low_at_done", fill_busy, 1'b0);
    end
  end

  initial begin
    logic        acc, hp, pw;
    logic [7:0]  hx_r, hy_r;
    logic [17:0] hd_r;
    int          i;

    pix_we = 0; pix_x = 0; pix_y = 0; pix_data = 0;
    host_valid = 0; host_x = 0; host_y = 0; host_data = 0;
    fill_start = 0; fill_color = 0;
    resetn = 1'b1;
    #1 resetn = 1'b0;
    model_reset();
    #1;
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 16'd0);
    chk("rst_mem_wdata", mem_wdata, 18'd0);
    chk("rst_fill_busy", fill_busy, m_busy);
    chk("rst_fill_done", fill_done, 1'b0);
    chk("rst_drop_cnt", drop_cnt, 8'd0);
    chk("rst_host_ready", host_ready, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk) resetn = 1'b1;

    // Corner pixel at the very last address
    cycle(1'b1, 8'd239, 8'd159, 18'h3FFFF, 1'b0, 8'd0, 8'd0, 18'd0, 1'b0, 18'd0, acc);
    // Pixel and host collide: host waits one cycle
    cycle(1'b1, 8'd0, 8'd0, 18'h0AAAA, 1'b1, 8'd1, 8'd0, 18'h15555, 1'b0, 18'd0, acc);
    chk("collide_host_not_acked", acc, 1'b0);
    cycle(1'b0, 8'd0, 8'd0, 18'd0, 1'b1, 8'd1, 8'd0, 18'h15555, 1'b0, 18'd0, acc);
    // Out-of-range host then pixel
    cycle(1'b0, 8'd0, 8'd0, 18'd0, 1'b1, 8'd240, 8'd5, 18'h12345, 1'b0, 18'd0, acc);
    cycle(1'b1, 8'd3, 8'd160, 18'h23456, 1'b0, 8'd0, 8'd0, 18'd0, 1'b0, 18'd0, acc);
    idle();
    chk("drop_cnt_after_two", drop_cnt, 8'd2);

    // Random pixel/host traffic with a held-until-accepted host
    hp = 0; hx_r = 0; hy_r = 0; hd_r = 0;
    for (int k = 0; k < 300; k++) begin
      pw = ($urandom_range(0, 2) == 0);
      if (!hp && $urandom_range(0, 2) == 0) begin
        hp = 1;
        hx_r = 8'($urandom_range(0, 255));
        hy_r = 8'($urandom_range(0, 191));
        hd_r = 18'($urandom);
      end
      cycle(pw, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 191)), 18'($urandom),
            hp, hx_r, hy_r, hd_r, 1'b0, 18'd0, acc);
      if (acc) hp = 0;
    end
    if (hp) cycle(1'b0, 8'd0, 8'd0, 18'd0, 1'b1, hx_r, hy_r, hd_r, 1'b0, 18'd0, acc);

    // Drop counter saturation
    for (int k = 0; k < 260; k++)
      cycle(1'b1, 8'(240 + $urandom_range(0, 15)), 8'($urandom_range(0, 159)), 18'd0,
            1'b0, 8'd0, 8'd0, 18'd0, 1'b0, 18'd0, acc);
    idle();
    chk("drop_cnt_saturated", drop_cnt, 8'hFF);

    // Abort a fill by reset once 1000 words are out
    cycle(1'b0, 8'd0, 8'd0, 18'd0, 1'b0, 8'd0, 8'd0, 18'd0, 1'b1, 18'h15A5A, acc);
    for (i = 0; !(m_busy && m_ptr >= 1000) && i < 50000; i++) idle();
    if (!(m_busy && m_ptr >= 1000)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL fill_progress_timeout: got %0d words expected 1000", m_ptr);
    end
    @(posedge clk);
    #3 resetn = 1'b0;
    model_reset();
    #1;
    chk("abort_mem_we", mem_we, 1'b0);
    chk("abort_mem_addr", mem_addr, 16'd0);
    chk("abort_mem_wdata", mem_wdata, 18'd0);
    chk("abort_fill_busy", fill_busy, m_busy);
    chk("abort_fill_done", fill_done, 1'b0);
    chk("abort_drop_cnt", drop_cnt, 8'd0);
    @(negedge clk) resetn = 1'b1;
    repeat (20) idle();

    // Full fill stretched by a pixel every third cycle; a second start mid-fill is ignored
    cycle(1'b0, 8'd0, 8'd0, 18'd0, 1'b0, 8'd0, 8'd0, 18'd0, 1'b1, 18'h00FC0, acc);
    for (i = 0; m_busy && i < 60000; i++)
      cycle((i % 3) == 2, 8'($urandom_range(0, 239)), 8'($urandom_range(0, 159)), 18'($urandom),
            1'b0, 8'd0, 8'd0, 18'd0, (i == 500), 18'h3FFFF, acc);
    if (m_busy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL fill_timeout: got %0d words expected 38400", m_ptr);
    end
    repeat (4) idle();

    chk("queue_drained", exp_q.size(), 0);
    chk("fill_done_count", done_seen, m_done_exp);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
